branch_commit_unit: RTL

Consumer side of the LI/ADDI/SUBI/branch execute unit's result interface. Accepts one execute result per handshake and commits it:
- register-file write for LI/ADDI/SUBI;
- S/V/Z/C flag register update;
- resolution of the unconditional B (is_10100) and conditional Bcc (is_10111) ops, with a PC redirect to fetch and a squash of wrong-path results.

Sits between the execute stage and register file / fetch.

---
 rtl/branch_commit_unit_pkg.sv | 21 ++
 rtl/branch_cond_eval.sv | 26 ++
 rtl/branch_commit_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/branch_commit_unit_pkg.sv
// Shared types and constants for the branch commit unit: FSM states,
// condition codes carried on ex_rd for Bcc, and bit positions inside {S,V,Z,C}.
package branch_commit_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational Bcc condition check: committed flags plus 3-bit code -> taken.
// Any code with the top bit set is never taken.
module branch_cond_eval
  import branch_commit_unit_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [2:0] i_code,
  output logic       o_taken
);

  logic w_lt;

  assign w_lt = i_flags[FLAG_S] ^ i_flags[FLAG_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_code)
      CC_BE:   o_taken = i_flags[FLAG_Z];
      CC_BLT:  o_taken = w_lt;
      CC_BLE:  o_taken = i_flags[FLAG_Z] | w_lt;
      CC_BNE:  o_taken = ~i_flags[FLAG_Z];
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_commit_unit.sv
// Commits execute results (register write, flag update) and resolves B/Bcc with a
// redirect to fetch plus squash of FLUSH_DEPTH wrong-path results. BRANCH_STATS_EN adds taken_cnt.
module branch_commit_unit
  import branch_commit_unit_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_out,
  input  logic        ex_s,
  input  logic        ex_v,
  input  logic        ex_z,
  input  logic        ex_c,
  input  logic        ex_svzc_we,
  input  logic        ex_rd_we,
  input  logic [2:0]  ex_rd,
  input  logic        ex_is_b,
  input  logic        ex_is_bcc,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  flags,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [15:0] redir_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt
`endif
);

  localparam logic [2:0] LP_FLUSH_CNT = 3'(FLUSH_DEPTH);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_rf_we;
  logic [2:0]  r_rf_waddr;
  logic [15:0] r_rf_wdata;
  logic [3:0]  r_flags;
  logic [15:0] r_redir_pc;

  logic w_accept, w_commit, w_is_branch, w_cond, w_taken, w_rf_write;

  assign ex_ready    = (r_state != REDIRECT);
  assign w_accept    = ex_valid & ex_ready;
  assign w_commit    = w_accept & (r_state == IDLE);
  assign w_is_branch = ex_is_b | ex_is_bcc;
  assign w_taken     = ex_is_b | (ex_is_bcc & w_cond);
  assign w_rf_write  = w_commit & ex_rd_we & ~w_is_branch;

  // Conditions see the flags committed before this accept, so a flag op
  // one cycle ahead is already visible here.
  branch_cond_eval u_cond (
    .i_flags (r_flags),
    .i_code  (ex_rd),
    .o_taken (w_cond)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_commit && w_taken) w_state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (redir_ready) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = LP_FLUSH_CNT;
        end
      end
      FLUSH: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // redir_pc only loads from IDLE, so it holds for the whole REDIRECT stay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 3'd0;
      r_rf_wdata <= 16'd0;
      r_flags    <= 4'd0;
      r_redir_pc <= 16'd0;
    end else begin
      r_rf_we <= w_rf_write;
      if (w_rf_write) begin
        r_rf_waddr <= ex_rd;
        r_rf_wdata <= ex_out;
      end
      if (w_commit && ex_svzc_we && !w_taken) r_flags <= {ex_s, ex_v, ex_z, ex_c};
      if (w_commit && w_taken) r_redir_pc <= ex_out;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_taken_cnt <= 16'd0;
    else if (w_commit && w_taken && (r_taken_cnt != 16'hFFFF)) r_taken_cnt <= r_taken_cnt + 16'd1;
  end

  assign taken_cnt = r_taken_cnt;
`endif

  assign rf_we       = r_rf_we;
  assign rf_waddr    = r_rf_waddr;
  assign rf_wdata    = r_rf_wdata;
  assign flags       = r_flags;
  assign redir_valid = (r_state == REDIRECT);
  assign redir_pc    = r_redir_pc;

endmodule
